// File: rtl/sub_unit_arbiter.sv
// sub_unit_arbiter: round-robin arbiter sharing one N-bit subtractor among
// NREQ requesters, with a single-entry valid/ready output slot.
// Optional feature macro: SUB_OVF_EN adds the registered signed-overflow
// output rsp_ovf.

// Plain N-bit adder with carry-in; subtraction is in1 + ~in2 + 1.
module N_bit_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic [N-1:0] sum
);

  assign sum = in1 + in2 + {{(N-1){1'b0}}, cin};

endmodule

module sub_unit_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
`ifdef SUB_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic [IDW-1:0]    rsp_id
);

  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t          state;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       ptr_next;
  logic [IDW-1:0]       cand;
  logic [IDW-1:0]       win_idx;
  logic [NREQ-1:0]      win;
  logic                 found;
  logic                 accept;
  logic                 issue;
  logic [N-1:0]         op_a;
  logic [N-1:0]         op_b;
  logic [N-1:0]         diff;

  assign rsp_valid = (state == FULL);

  // The slot can take a new result when it is empty or draining this cycle.
  assign accept = ~rsp_valid | rsp_ready;

  // Scan requesters starting at ptr, wrapping; the first valid one wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found      = 1'b1;
        win[cand]  = 1'b1;
        win_idx    = cand;
      end
    end
  end

  assign req_ready = (accept && !reset) ? win : '0;
  assign issue     = accept & found;

  assign op_a = req_a[win_idx*N +: N];
  assign op_b = req_b[win_idx*N +: N];

  N_bit_adder #(.N(N)) u_sub (
    .in1 (op_a),
    .in2 (~op_b),
    .cin (1'b1),
    .sum (diff)
  );

  assign ptr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef SUB_OVF_EN
  logic diff_ovf;
  assign diff_ovf = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
`endif

  // Slot state machine: load on issue, drain on consumer handshake, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      ptr      <= '0;
`ifdef SUB_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else if (issue) begin
      state    <= FULL;
      rsp_data <= diff;
      rsp_id   <= win_idx;
      ptr      <= ptr_next;
`ifdef SUB_OVF_EN
      rsp_ovf  <= diff_ovf;
`endif
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_sub_unit_arbiter.sv
// Testbench for sub_unit_arbiter: table-driven vectors over a fixed operand
// set plus hand-written round-robin and mid-stream reset sequences.
// Overflow checks are compiled in only when SUB_OVF_EN is defined.
module tb_sub_unit_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
`ifdef SUB_OVF_EN
  logic              rsp_ovf;
`endif

  typedef struct {
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_id;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[19];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sub_unit_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef SUB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the per-cycle control inputs.
  task automatic applyStimulus(input logic [3:0] v, input logic r);
    req_valid = v;
    rsp_ready = r;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Operands: d0=7, d1=60, d2=0xFFFFFFFF (ovf 0), d3=0x7FFFFFFF (ovf 1)
    req_a = {32'h8000_0000, 32'd0, 32'd100, 32'd10};
    req_b = {32'd1,         32'd1, 32'd40,  32'd3};

    //            valid    rdy   exp_ready exp_v  exp_data        id    ovf
    vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'd60,         2'd1, 1'b0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'hFFFF_FFFF,  2'd2, 1'b0};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'h7FFF_FFFF,  2'd3, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'd60,         2'd1, 1'b0};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0,          2'd0, 1'b0};
    vecs[7]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[8]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[11] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 32'd60,         2'd1, 1'b0};
    vecs[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[13] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 32'hFFFF_FFFF,  2'd2, 1'b0};
    vecs[14] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[15] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 32'd7,          2'd0, 1'b0};
    vecs[16] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 32'h7FFF_FFFF,  2'd3, 1'b1};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 32'h7FFF_FFFF,  2'd3, 1'b1};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0,          2'd0, 1'b0};

    // Reset state, with requests pending to show req_ready is gated.
    reset = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
`ifdef SUB_OVF_EN
    checkOutput("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif

    // Round robin with every requester busy: ids 0,1,2,3,0,1.
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      checkOutput($sformatf("rr%0d_valid", c), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("rr%0d_id", c), 32'(rsp_id), 32'(c % 4));
    end

    // Return to a known state for the table (ptr=0, slot empty).
    reset = 1'b1;
    #2;
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    stepCycle();

    // Table-driven vectors; each row is one cycle.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rdy);
      #1;
      checkOutput($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      stepCycle();
      checkOutput($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("row%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
        checkOutput($sformatf("row%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
`ifdef SUB_OVF_EN
        checkOutput($sformatf("row%0d_rsp_ovf", i), 32'(rsp_ovf), 32'(vecs[i].exp_ovf));
`endif
      end
    end

    // Mid-stream reset: slot full and ptr advanced to 2, then reset hits.
    applyStimulus(4'b1111, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("mid_pre_valid", 32'(rsp_valid), 32'd1);
    checkOutput("mid_pre_id", 32'(rsp_id), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_req_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rsp_data", rsp_data, 32'd0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(4'b0110, 1'b1);
    #1;
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'b0010);
    stepCycle();
    checkOutput("post_reset_valid", 32'(rsp_valid), 32'd1);
    checkOutput("post_reset_data", rsp_data, 32'd60);
    checkOutput("post_reset_id", 32'(rsp_id), 32'd1);

    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
